// File: rtl/rc5_stable_arbiter_if.sv
// ---------------------------------------------------------------------------
// rc5_stable_arbiter_if
// Bundles the request/grant handshakes and table access buses between the
// RC5 round-key table arbiter and its three clients (key expansion, cipher,
// decipher).
//
// Parameters:
//   W        - table word width
//   T_LENGTH - table address width
//
// Modports:
//   master - client side: drives requests, addresses and write data,
//            receives grants, read data, table-valid and timeout status
//   slave  - arbiter side: the mirror image of master
// ---------------------------------------------------------------------------
interface rc5_stable_arbiter_if #(
    parameter int W        = 32,
    parameter int T_LENGTH = 5
);
    // Key expansion port
    logic                iKey_req;
    logic                oKey_gnt;
    logic                iKey_we;
    logic [T_LENGTH-1:0] iKey_waddr;
    logic [W-1:0]        iKey_wdata;
    logic [T_LENGTH-1:0] iKey_raddr;
    logic [W-1:0]        oKey_rdata;

    // Cipher port
    logic                iEnc_req;
    logic                oEnc_gnt;
    logic [T_LENGTH-1:0] iEnc_addr1;
    logic [T_LENGTH-1:0] iEnc_addr2;
    logic [W-1:0]        oEnc_data1;
    logic [W-1:0]        oEnc_data2;

    // Decipher port
    logic                iDec_req;
    logic                oDec_gnt;
    logic [T_LENGTH-1:0] iDec_addr1;
    logic [T_LENGTH-1:0] iDec_addr2;
    logic [W-1:0]        oDec_data1;
    logic [W-1:0]        oDec_data2;

    // Status
    logic                oTable_valid;
    logic                oTimeout;

    modport master (
        output iKey_req, iKey_we, iKey_waddr, iKey_wdata, iKey_raddr,
        output iEnc_req, iEnc_addr1, iEnc_addr2,
        output iDec_req, iDec_addr1, iDec_addr2,
        input  oKey_gnt, oKey_rdata,
        input  oEnc_gnt, oEnc_data1, oEnc_data2,
        input  oDec_gnt, oDec_data1, oDec_data2,
        input  oTable_valid, oTimeout
    );

    modport slave (
        input  iKey_req, iKey_we, iKey_waddr, iKey_wdata, iKey_raddr,
        input  iEnc_req, iEnc_addr1, iEnc_addr2,
        input  iDec_req, iDec_addr1, iDec_addr2,
        output oKey_gnt, oKey_rdata,
        output oEnc_gnt, oEnc_data1, oEnc_data2,
        output oDec_gnt, oDec_data1, oDec_data2,
        output oTable_valid, oTimeout
    );
endinterface

// File: rtl/rc5_stable_arbiter.sv
// ---------------------------------------------------------------------------
// rc5_stable_arbiter
// Owns the RC5 round-key table S[0..T-1], T = 2*(R+1), with one write port
// and registered read ports, and arbitrates it between key expansion
// (absolute priority), cipher and decipher (round-robin between the two).
// A grant is held until the owner drops its request; there is always at
// least one IDLE cycle between grants.
//
// Ports:
//   clk - clock
//   rst - synchronous active-high reset (table contents are kept)
//   bus - rc5_stable_arbiter_if.slave: requests/grants, key write port,
//         key read port, two cipher and two decipher read ports,
//         oTable_valid and oTimeout status
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Adds parameter MAX_HOLD and a grant watchdog. After MAX_HOLD granted
//   cycles the grant is revoked, oTimeout pulses for one cycle and the
//   revoked requester is locked out until it drops its request once.
//   Without the macro grants are held indefinitely and oTimeout is 0.
// ---------------------------------------------------------------------------
module rc5_stable_arbiter #(
    parameter int W        = 32,
    parameter int R        = 12,
    parameter int T_LENGTH = $clog2(2*(R+1))
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 255
`endif
) (
    input  logic                clk,
    input  logic                rst,
    rc5_stable_arbiter_if.slave bus
);
    localparam int T = 2*(R+1);

    typedef enum logic [1:0] {IDLE, GNT_KEY, GNT_ENC, GNT_DEC} stateT;

    stateT        state;
    stateT        nextState;
    logic [W-1:0] sTable [T];
    logic         tableValid;
    logic         favourDec;
    logic         timeoutHit;
    logic         keyReqOk;
    logic         encReqOk;
    logic         decReqOk;

    logic [W-1:0] keyRdata;
    logic [W-1:0] encData1;
    logic [W-1:0] encData2;
    logic [W-1:0] decData1;
    logic [W-1:0] decData2;

    // Out-of-range addresses read as zero instead of aliasing into the table.
    function automatic logic [W-1:0] readWord(input logic [T_LENGTH-1:0] addr);
        if (int'(addr) < T) begin
            return sTable[addr];
        end
        return '0;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] holdCount;
    logic              holdExpired;
    logic              blockKey;
    logic              blockEnc;
    logic              blockDec;
    logic              timeoutPulse;

    assign holdExpired = (holdCount == HOLD_W'(MAX_HOLD - 1));

    // A timeout only counts while the owner still wants the table; a normal
    // release on the same edge takes precedence.
    assign timeoutHit = holdExpired &&
                        ((state == GNT_KEY && bus.iKey_req) ||
                         (state == GNT_ENC && bus.iEnc_req) ||
                         (state == GNT_DEC && bus.iDec_req));

    assign keyReqOk = bus.iKey_req & ~blockKey;
    assign encReqOk = bus.iEnc_req & ~blockEnc;
    assign decReqOk = bus.iDec_req & ~blockDec;

    // Hold counter restarts on every grant entry; a lockout clears once the
    // revoked requester has been seen with its request low.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdCount    <= '0;
            blockKey     <= 1'b0;
            blockEnc     <= 1'b0;
            blockDec     <= 1'b0;
            timeoutPulse <= 1'b0;
        end else begin
            if (state == IDLE || nextState == IDLE) begin
                holdCount <= '0;
            end else begin
                holdCount <= holdCount + 1'b1;
            end
            blockKey     <= (timeoutHit && state == GNT_KEY) | (blockKey & bus.iKey_req);
            blockEnc     <= (timeoutHit && state == GNT_ENC) | (blockEnc & bus.iEnc_req);
            blockDec     <= (timeoutHit && state == GNT_DEC) | (blockDec & bus.iDec_req);
            timeoutPulse <= timeoutHit;
        end
    end

    assign bus.oTimeout = timeoutPulse;
`else
    assign timeoutHit   = 1'b0;
    assign keyReqOk     = bus.iKey_req;
    assign encReqOk     = bus.iEnc_req;
    assign decReqOk     = bus.iDec_req;
    assign bus.oTimeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Grant states only ever return to IDLE, which forces
    // at least one idle cycle between owners and rules out preemption.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (keyReqOk) begin
                    nextState = GNT_KEY;
                end else if (tableValid) begin
                    if (encReqOk && decReqOk) begin
                        nextState = favourDec ? GNT_DEC : GNT_ENC;
                    end else if (encReqOk) begin
                        nextState = GNT_ENC;
                    end else if (decReqOk) begin
                        nextState = GNT_DEC;
                    end
                end
            end
            GNT_KEY: begin
                if (!bus.iKey_req || timeoutHit) begin
                    nextState = IDLE;
                end
            end
            GNT_ENC: begin
                if (!bus.iEnc_req || timeoutHit) begin
                    nextState = IDLE;
                end
            end
            GNT_DEC: begin
                if (!bus.iDec_req || timeoutHit) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Table validity falls when key expansion starts and rises only when it
    // finishes by releasing; a revoked expansion leaves the table invalid.
    // The round-robin pointer records who was granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            tableValid <= 1'b0;
            favourDec  <= 1'b0;
        end else begin
            if (state == IDLE && nextState == GNT_KEY) begin
                tableValid <= 1'b0;
            end else if (state == GNT_KEY && nextState == IDLE && !timeoutHit) begin
                tableValid <= 1'b1;
            end
            if (state == IDLE && nextState == GNT_ENC) begin
                favourDec <= 1'b1;
            end else if (state == IDLE && nextState == GNT_DEC) begin
                favourDec <= 1'b0;
            end
        end
    end

    // Table write port. The table is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && state == GNT_KEY && bus.iKey_we && int'(bus.iKey_waddr) < T) begin
            sTable[bus.iKey_waddr] <= bus.iKey_wdata;
        end
    end

    // Registered read ports. Only the owner's outputs follow the table; all
    // others are held at zero. A same-cycle write is not forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            keyRdata <= '0;
            encData1 <= '0;
            encData2 <= '0;
            decData1 <= '0;
            decData2 <= '0;
        end else begin
            keyRdata <= (state == GNT_KEY) ? readWord(bus.iKey_raddr) : '0;
            encData1 <= (state == GNT_ENC) ? readWord(bus.iEnc_addr1) : '0;
            encData2 <= (state == GNT_ENC) ? readWord(bus.iEnc_addr2) : '0;
            decData1 <= (state == GNT_DEC) ? readWord(bus.iDec_addr1) : '0;
            decData2 <= (state == GNT_DEC) ? readWord(bus.iDec_addr2) : '0;
        end
    end

    assign bus.oKey_gnt     = (state == GNT_KEY);
    assign bus.oEnc_gnt     = (state == GNT_ENC);
    assign bus.oDec_gnt     = (state == GNT_DEC);
    assign bus.oTable_valid = tableValid;
    assign bus.oKey_rdata   = keyRdata;
    assign bus.oEnc_data1   = encData1;
    assign bus.oEnc_data2   = encData2;
    assign bus.oDec_data1   = decData1;
    assign bus.oDec_data2   = decData2;
endmodule

// File: tb/tb_rc5_stable_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rc5_stable_arbiter
// Directed bench for rc5_stable_arbiter: reset state, invalid-table lockout,
// key schedule load, cipher/decipher reads, round-robin contention, key
// priority without preemption, mid-operation reset and, when ARB_TIMEOUT_EN
// is defined, the grant watchdog on a second instance with MAX_HOLD = 8.
// ---------------------------------------------------------------------------
module tb_rc5_stable_arbiter;
    localparam int W  = 32;
    localparam int R  = 12;
    localparam int TL = 5;

    localparam logic [2:0] OWN_IDLE = 3'b000;
    localparam logic [2:0] OWN_KEY  = 3'b001;
    localparam logic [2:0] OWN_ENC  = 3'b010;
    localparam logic [2:0] OWN_DEC  = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errorCount = 0;
    int   checkCount = 0;
    logic seenGnt;
    logic [W-1:0] dataOr;
    logic [2:0] rrExpect [14];

    always #5 clk = ~clk;

    rc5_stable_arbiter_if #(.W(W), .T_LENGTH(TL)) bus ();

    rc5_stable_arbiter #(.W(W), .R(R), .T_LENGTH(TL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef ARB_TIMEOUT_EN
    int gntSamples;
    int pulses;
    int firstPulse;

    rc5_stable_arbiter_if #(.W(W), .T_LENGTH(TL)) bus8 ();

    rc5_stable_arbiter #(.W(W), .R(R), .T_LENGTH(TL), .MAX_HOLD(8)) dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );
`endif

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic keyReq, input logic encReq, input logic decReq);
        bus.iKey_req = keyReq;
        bus.iEnc_req = encReq;
        bus.iDec_req = decReq;
        tick();
    endtask

    function automatic logic [31:0] keyWord(input int k);
        logic [31:0] v;
        v = 32'hB7E15163 + 32'(k) * 32'h9E3779B9;
        return v;
    endfunction

    function automatic logic [2:0] owner();
        return {bus.oDec_gnt, bus.oEnc_gnt, bus.oKey_gnt};
    endfunction

    initial begin
        bus.iKey_req = 0; bus.iKey_we = 0; bus.iKey_waddr = '0; bus.iKey_wdata = '0; bus.iKey_raddr = '0;
        bus.iEnc_req = 0; bus.iEnc_addr1 = '0; bus.iEnc_addr2 = '0;
        bus.iDec_req = 0; bus.iDec_addr1 = '0; bus.iDec_addr2 = '0;
`ifdef ARB_TIMEOUT_EN
        bus8.iKey_req = 0; bus8.iKey_we = 0; bus8.iKey_waddr = '0; bus8.iKey_wdata = '0; bus8.iKey_raddr = '0;
        bus8.iEnc_req = 0; bus8.iEnc_addr1 = '0; bus8.iEnc_addr2 = '0;
        bus8.iDec_req = 0; bus8.iDec_addr1 = '0; bus8.iDec_addr2 = '0;
`endif
        rrExpect = '{OWN_ENC, OWN_ENC, OWN_ENC, OWN_ENC, OWN_ENC, OWN_IDLE,
                     OWN_DEC, OWN_DEC, OWN_DEC, OWN_DEC, OWN_DEC, OWN_IDLE,
                     OWN_ENC, OWN_ENC};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rstOwner", 32'(owner()), 32'(OWN_IDLE));
        checkOutput("rstValid", 32'(bus.oTable_valid), 32'd0);
        checkOutput("rstTimeout", 32'(bus.oTimeout), 32'd0);
        checkOutput("rstData", bus.oKey_rdata | bus.oEnc_data1 | bus.oEnc_data2 | bus.oDec_data1 | bus.oDec_data2, 32'd0);

        // Cipher request with an invalid table is never granted
        bus.iEnc_req = 1'b1;
        seenGnt = 1'b0;
        dataOr  = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seenGnt = seenGnt | bus.oEnc_gnt;
            dataOr  = dataOr | bus.oEnc_data1 | bus.oEnc_data2 | bus.oDec_data1 | bus.oDec_data2 | bus.oKey_rdata;
        end
        checkOutput("encGntInvalid", 32'(seenGnt), 32'd0);
        checkOutput("dataZeroInvalid", dataOr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Key schedule load
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("keyGnt", 32'(owner()), 32'(OWN_KEY));
        checkOutput("keyValidLow", 32'(bus.oTable_valid), 32'd0);
        for (int k = 0; k < 26; k++) begin
            bus.iKey_we    = 1'b1;
            bus.iKey_waddr = 5'(k);
            bus.iKey_wdata = keyWord(k);
            tick();
        end
        bus.iKey_waddr = 5'd5;
        bus.iKey_wdata = 32'hDEADBEEF;
        bus.iKey_raddr = 5'd5;
        tick();
        checkOutput("keyRdOldOnWrite", bus.oKey_rdata, keyWord(5));
        bus.iKey_wdata = keyWord(5);
        tick();
        checkOutput("keyRdAfterWrite", bus.oKey_rdata, 32'hDEADBEEF);
        bus.iKey_we = 1'b0;
        tick();
        checkOutput("keyRdRestored", bus.oKey_rdata, keyWord(5));
        bus.iKey_raddr = 5'd26;
        tick();
        checkOutput("keyRdOutOfRange", bus.oKey_rdata, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("keyReleaseOwner", 32'(owner()), 32'(OWN_IDLE));
        checkOutput("keyReleaseValid", 32'(bus.oTable_valid), 32'd1);

        // Cipher reads
        bus.iEnc_addr1 = 5'd0;
        bus.iEnc_addr2 = 5'd1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("encGnt", 32'(owner()), 32'(OWN_ENC));
        checkOutput("encDataBeforeRead", bus.oEnc_data1, 32'd0);
        tick();
        checkOutput("encData1", bus.oEnc_data1, 32'hB7E15163);
        checkOutput("encData2", bus.oEnc_data2, 32'h5618CB1C);
        bus.iEnc_addr1 = 5'd26;
        bus.iEnc_addr2 = 5'd25;
        tick();
        checkOutput("encData1OutOfRange", bus.oEnc_data1, 32'd0);
        checkOutput("encData2Last", bus.oEnc_data2, keyWord(25));
        checkOutput("decDataIdle", bus.oDec_data1 | bus.oDec_data2, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("encDataCleared", bus.oEnc_data2, 32'd0);

        // Decipher reads
        bus.iDec_addr1 = 5'd2;
        bus.iDec_addr2 = 5'd30;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("decGnt", 32'(owner()), 32'(OWN_DEC));
        tick();
        checkOutput("decData1", bus.oDec_data1, keyWord(2));
        checkOutput("decData2OutOfRange", bus.oDec_data2, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();

        // Round-robin contention, each owner releasing after 5 granted cycles
        bus.iEnc_req = 1'b1;
        bus.iDec_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            checkOutput($sformatf("rrOwner%0d", c), 32'(owner()), 32'(rrExpect[c-1]));
            if (c == 5)  bus.iEnc_req = 1'b0;
            if (c == 6)  bus.iEnc_req = 1'b1;
            if (c == 11) bus.iDec_req = 1'b0;
            if (c == 12) bus.iDec_req = 1'b1;
        end

        // Key request cannot preempt the decipher; an ungranted write is ignored
        bus.iEnc_req = 1'b0;
        tick();
        tick();
        checkOutput("decBeforeKey", 32'(owner()), 32'(OWN_DEC));
        bus.iKey_req   = 1'b1;
        bus.iKey_we    = 1'b1;
        bus.iKey_waddr = 5'd0;
        bus.iKey_wdata = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("noPreempt%0d", i), 32'(owner()), 32'(OWN_DEC));
        end
        bus.iKey_we = 1'b0;
        bus.iEnc_req = 1'b1;
        bus.iDec_req = 1'b0;
        tick();
        checkOutput("decReleaseOwner", 32'(owner()), 32'(OWN_IDLE));
        checkOutput("decReleaseValid", 32'(bus.oTable_valid), 32'd1);
        bus.iKey_raddr = 5'd0;
        tick();
        checkOutput("keyWinsOwner", 32'(owner()), 32'(OWN_KEY));
        checkOutput("keyWinsValid", 32'(bus.oTable_valid), 32'd0);
        tick();
        checkOutput("tableUnchanged", bus.oKey_rdata, 32'hB7E15163);
        bus.iKey_req = 1'b0;
        tick();
        checkOutput("keyDoneValid", 32'(bus.oTable_valid), 32'd1);
        tick();
        checkOutput("encAfterKey", 32'(owner()), 32'(OWN_ENC));

        // Reset in the middle of a cipher grant
        bus.iEnc_addr1 = 5'd3;
        tick();
        checkOutput("encDataPreReset", bus.oEnc_data1, keyWord(3));
        rst = 1'b1;
        tick();
        checkOutput("midResetOwner", 32'(owner()), 32'(OWN_IDLE));
        checkOutput("midResetValid", 32'(bus.oTable_valid), 32'd0);
        checkOutput("midResetData", bus.oEnc_data1 | bus.oEnc_data2, 32'd0);
        rst = 1'b0;
        bus.iEnc_req = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog on the MAX_HOLD = 8 instance
        bus8.iKey_req = 1'b1;
        tick();
        bus8.iKey_req = 1'b0;
        tick();
        checkOutput("wdValid", 32'(bus8.oTable_valid), 32'd1);
        bus8.iEnc_req = 1'b1;
        gntSamples = 0;
        pulses     = 0;
        firstPulse = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus8.oEnc_gnt) gntSamples++;
            if (bus8.oTimeout) begin
                pulses++;
                if (firstPulse < 0) firstPulse = i;
            end
        end
        checkOutput("wdGrantCycles", 32'(gntSamples), 32'd8);
        checkOutput("wdPulseCount", 32'(pulses), 32'd1);
        checkOutput("wdPulseCycle", 32'(firstPulse), 32'd8);
        checkOutput("wdNoRegrant", 32'(bus8.oEnc_gnt), 32'd0);
        bus8.iEnc_req = 1'b0;
        tick();
        bus8.iEnc_req = 1'b1;
        tick();
        checkOutput("wdRegrant", 32'(bus8.oEnc_gnt), 32'd1);
        bus8.iEnc_req = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/rc5_stable_arbiter.md
Name: rc5_stable_arbiter

Overview:
- Owns the RC5 round-key table S[0..T-1] (T = 2*(R+1) words of W bits): one write port and two registered read ports.
- Arbitrates the table between three requesters: key expansion (writer/reader), cipher core and decipher core.
- Key expansion has absolute priority. Cipher and decipher alternate round-robin.
- A grant is held for a whole operation and released when the requester drops its request.

Parameters:
W, 32, word width of table entries
R, 12, number of rounds; table depth T = 2*(R+1)
T_LENGTH, $clog2(2*(R+1)), address width (5 for defaults)
MAX_HOLD, 255, grant watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iKey_req  in  1  key expansion requests table
oKey_gnt  out  1  key expansion owns table
iKey_we  in  1  write strobe (honoured only while oKey_gnt)
iKey_waddr  in  T_LENGTH  write address
iKey_wdata  in  W  write data
iKey_raddr  in  T_LENGTH  key expansion read address
oKey_rdata  out  W  registered read data for iKey_raddr
iEnc_req  in  1  cipher requests table
oEnc_gnt  out  1  cipher owns table
iEnc_addr1  in  T_LENGTH  cipher read address 1
iEnc_addr2  in  T_LENGTH  cipher read address 2
oEnc_data1  out  W  registered S[iEnc_addr1]
oEnc_data2  out  W  registered S[iEnc_addr2]
iDec_req  in  1  decipher requests table
oDec_gnt  out  1  decipher owns table
iDec_addr1  in  T_LENGTH  decipher read address 1
iDec_addr2  in  T_LENGTH  decipher read address 2
oDec_data1  out  W  registered S[iDec_addr1]
oDec_data2  out  W  registered S[iDec_addr2]
oTable_valid  out  1  table holds a complete key schedule
oTimeout  out  1  one-cycle pulse on watchdog revocation (ARB_TIMEOUT_EN only)

Behaviour:
- Reset: all grants 0, oTable_valid 0, all data outputs 0, oTimeout 0, state IDLE, round-robin pointer favours cipher. Table contents are not cleared.
- Reset mid-operation drops every grant on the next edge. Writes in the reset cycle are ignored.
- FSM states: IDLE, GNT_KEY, GNT_ENC, GNT_DEC. Grant outputs are registered and decoded from the state.
- IDLE transitions, in priority order:
  - iKey_req -> GNT_KEY; oTable_valid clears on the same edge.
  - oTable_valid and exactly one of iEnc_req/iDec_req -> that requester's grant state.
  - oTable_valid and both -> the one not served last; the pointer updates on entry.
  - Enc/dec requests are never granted while oTable_valid = 0.
- GNT_x: stay while iX_req = 1. When iX_req = 0, go to IDLE. IDLE always lasts at least one cycle between grants (no back-to-back handover). No preemption, including by iKey_req.
- Leaving GNT_KEY sets oTable_valid = 1.
- Write: S[iKey_waddr] <= iKey_wdata at the edge where state = GNT_KEY and iKey_we = 1.
- Read latency is 1 cycle: data presented at edge n reflects the address sampled at edge n.
  - Reading the address being written in the same cycle returns the old value.
  - Only the granted requester's data outputs update. Ungranted requesters' outputs are forced to 0 on the next edge.
- Addresses >= T: reads return 0, writes are dropped.
- Requests are level signals. A requester may deassert its request on the cycle after its final read is sampled.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter runs in each GNT_x state.
  - After MAX_HOLD consecutive granted cycles the FSM forces IDLE and pulses oTimeout for 1 cycle.
  - If GNT_KEY timed out, oTable_valid stays 0.
  - The revoked requester is not regranted until it deasserts its request for at least 1 cycle.
- Without the macro: no counter; grants are held indefinitely; oTimeout is tied to 0.

Test Plan:
- Reset, then iEnc_req = 1 with table invalid -> oEnc_gnt stays 0 for 20 cycles; all data outputs 0.
- Key write: iKey_req, write S[k] = 0xB7E15163 + k*0x9E3779B9 for k = 0..25, drop request -> oTable_valid = 1 one cycle after GNT_KEY exits.
- Cipher reads: grant cipher, addr1 = 0, addr2 = 1 -> next cycle oEnc_data1 = 0xB7E15163, oEnc_data2 = 0x5618CB1C; addr1 = 26 -> oEnc_data1 = 0.
- Contention: iEnc_req and iDec_req asserted together, each held 5 cycles then dropped and reasserted -> grants go cipher, decipher, cipher, with exactly 1 IDLE cycle between grants.
- Key priority:
  - iKey_req raised during GNT_DEC -> no preemption.
  - Once the decipher releases, with iKey_req and iEnc_req both high, GNT_KEY wins and oTable_valid falls.
  - A write with oKey_gnt = 0 leaves the table unchanged.
- With ARB_TIMEOUT_EN and MAX_HOLD = 8: cipher holds its request 20 cycles -> grant drops after 8 cycles, oTimeout pulses once, and no regrant occurs until the request toggles.
